mux8_rr_arbiter: RTL and testbench

MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

---
 rtl/mux8_arb_pkg.sv | 18 +
 rtl/mux8_rr_arbiter_if.sv | 13 +
 rtl/mux8_rr_arbiter_pick.sv | 27 ++
 rtl/mux8_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/mux8_arb_pkg.sv
// Shared types and constants for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant and mux-control bundle between requesters and the arbiter.
interface mux8_rr_arbiter_if;
  import mux8_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] mux_sel;
  logic             mux_en_n;
  logic             busy;

  modport master (output req, input gnt, mux_sel, mux_en_n, busy);
  modport slave  (input req, output gnt, mux_sel, mux_en_n, busy);
endinterface

// File: rtl/mux8_rr_arbiter_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping 7->0.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] win_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] idx;

  // Scan from farthest to nearest offset so the nearest set bit is assigned last.
  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr_i + IDX_W'(i);
      if (req_i[idx]) begin
        win_o   = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for a shared 8:1 mux with hold limit and break-before-make gap.
// Define MUX8_ARB_PRIO0_EN to make requester 0 a preempting high-priority requester.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux8_rr_arbiter_if.slave     arb
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             en_n_q, en_n_d;
  logic             busy_q, busy_d;

  logic [IDX_W-1:0] rr_win;
  logic             rr_valid;
  logic [IDX_W-1:0] win;
  logic             win_valid;
  logic             upd_ptr;
  logic             preempt;
  logic             hold_end;

  rr_pick8 u_pick (
    .req_i   (arb.req),
    .ptr_i   (ptr_q),
    .win_o   (rr_win),
    .valid_o (rr_valid)
  );

`ifdef MUX8_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation and does not move the pointer.
  always_comb begin
    win       = rr_win;
    win_valid = rr_valid;
    upd_ptr   = 1'b1;
    if (arb.req[0]) begin
      win     = '0;
      upd_ptr = 1'b0;
    end
    preempt = arb.req[0] && (sel_q != '0);
  end
`else
  assign win       = rr_win;
  assign win_valid = rr_valid;
  assign upd_ptr   = 1'b1;
  assign preempt   = 1'b0;
`endif

  assign hold_end = !arb.req[sel_q] || (cnt_q == CNT_LAST) || preempt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    en_n_d  = en_n_q;
    case (state_q)
      IDLE, GAP: begin
        gnt_d   = '0;
        en_n_d  = 1'b1;
        state_d = IDLE;
        if (win_valid) begin
          state_d = GRANT;
          gnt_d   = idx2onehot(win);
          sel_d   = win;
          en_n_d  = 1'b0;
          cnt_d   = '0;
          if (upd_ptr) begin
            ptr_d = win + IDX_W'(1);
          end
        end
      end
      GRANT: begin
        if (hold_end) begin
          state_d = GAP;
          gnt_d   = '0;
          en_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        en_n_d  = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      en_n_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      en_n_q  <= en_n_d;
      busy_q  <= busy_d;
    end
  end

  assign arb.gnt      = gnt_q;
  assign arb.mux_sel  = sel_q;
  assign arb.mux_en_n = en_n_q;
  assign arb.busy     = busy_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed self-checking bench for mux8_rr_arbiter (HOLD_CYCLES = 4).
module tb_mux8_rr_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mux8_rr_arbiter_if arb ();

  mux8_rr_arbiter #(.HOLD_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input int gnt, input int sel, input int en_n, input int busy);
    chk({tag, ".gnt"},      32'(arb.gnt),      32'(gnt));
    chk({tag, ".mux_sel"},  32'(arb.mux_sel),  32'(sel));
    chk({tag, ".mux_en_n"}, 32'(arb.mux_en_n), 32'(en_n));
    chk({tag, ".busy"},     32'(arb.busy),     32'(busy));
  endtask

  // n grant cycles on idx followed by one gap cycle
  task automatic grant_run(input string tag, input int idx, input int n);
    for (int c = 0; c < n; c++) begin
      cyc();
      expect_out($sformatf("%s.g%0d.c%0d", tag, idx, c), 1 << idx, idx, 0, 1);
    end
    cyc();
    expect_out($sformatf("%s.gap%0d", tag, idx), 0, idx, 1, 1);
  endtask

  task automatic do_reset();
    arb.req = '0;
    rst_n   = 1'b0;
    cyc();
    rst_n   = 1'b1;
  endtask

  // Per-cycle invariants
  logic       prev_en_n;
  logic [2:0] prev_sel;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv.onehot0", 32'($onehot0(arb.gnt)), 32'd1);
      chk("inv.en_vs_gnt", 32'(arb.mux_en_n), 32'(arb.gnt == '0));
      if (!prev_en_n && !arb.mux_en_n) begin
        chk("inv.sel_stable", 32'(arb.mux_sel), 32'(prev_sel));
      end
      prev_en_n <= arb.mux_en_n;
      prev_sel  <= arb.mux_sel;
    end else begin
      prev_en_n <= 1'b1;
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    arb.req  = '0;
    cyc();
    cyc();
    expect_out("reset", 0, 0, 1, 0);
    rst_n = 1'b1;

    // Two-cycle request from requester 2
    arb.req = 8'h04;
    cyc();
    expect_out("r027.c0", 8'h04, 2, 0, 1);
    cyc();
    expect_out("r027.c1", 8'h04, 2, 0, 1);
    arb.req = 8'h00;
    cyc();
    expect_out("r027.gap", 0, 2, 1, 1);
    cyc();
    expect_out("r027.idle", 0, 2, 1, 0);

    // All requesting: full rotation and wrap to 0
    do_reset();
    arb.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      grant_run("r028", k % 8, 4);
    end
    cyc();
    expect_out("r026.pre", 8'h02, 1, 0, 1);

    // Asynchronous reset in the middle of a grant
    #2 rst_n = 1'b0;
    #1 expect_out("r026.async", 0, 0, 1, 0);
    arb.req = '0;
    cyc();
    rst_n = 1'b1;

    // Requesters 0 and 7 alternate
    arb.req = 8'h81;
    grant_run("r029", 0, 4);
    grant_run("r029", 7, 4);
    grant_run("r029", 0, 4);
    grant_run("r029", 7, 4);
    arb.req = 8'h00;
    cyc();
    expect_out("r029.idle", 0, 7, 1, 0);

    // Requester 0 arrives while 5 holds the grant
    do_reset();
    arb.req = 8'h20;
    cyc();
    expect_out("r030.g5", 8'h20, 5, 0, 1);
    arb.req = 8'h21;
`ifdef MUX8_ARB_PRIO0_EN
    cyc();
    expect_out("r030.preempt_gap", 0, 5, 1, 1);
`else
    for (int c = 1; c < 4; c++) begin
      cyc();
      expect_out($sformatf("r030.g5.c%0d", c), 8'h20, 5, 0, 1);
    end
    cyc();
    expect_out("r030.gap", 0, 5, 1, 1);
`endif
    cyc();
    expect_out("r030.g0", 8'h01, 0, 0, 1);
    arb.req = 8'h00;
    cyc();
    expect_out("r030.gap0", 0, 0, 1, 1);
    cyc();
    expect_out("r030.idle", 0, 0, 1, 0);

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
